serial_bit_feeder: RTL and testbench

Parallel-to-serial front end for the serial sequence-detector path. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on a single-bit stream that the downstream pattern detectors sample every cycle. A one-word holding register lets back-to-back words stream with no idle gap between them. When no word is in flight, the stream is driven to a fixed idle level.

---
 rtl/serial_pkg.sv | 29 ++
 rtl/ser_hold_reg.sv | 59 +++++
 rtl/serial_bit_feeder.sv | 221 ++++++++++++++++++++++
 tb/tb_serial_bit_feeder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
//
// Shared definitions for the serial sequence-detector front end.
//   state_t        : shifter states (IDLE, SHIFT, PARITY)
//   SER_MAX_WIDTH  : widest word the feeder supports
//   clog2()        : ceiling log2, used to size bit counters
// ---------------------------------------------------------------------------
package serial_pkg;

    localparam int SER_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// ---------------------------------------------------------------------------
// ser_hold_reg
//
// One-entry holding register with a valid/ready write side.
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset (clears full flag only)
//   clear     in   synchronous discard of the held entry
//   in_valid  in   write request
//   in_data   in   data to store
//   in_ready  out  entry is free and can take a write
//   pop       in   consumer takes the held entry this edge
//   out_data  out  held data
//   full      out  entry holds valid data
// The data register carries no reset; only the full flag is control state.
// ---------------------------------------------------------------------------
module ser_hold_reg
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             pop,
    output logic [WIDTH-1:0] out_data,
    output logic             full
);

    logic             full_q;
    logic [WIDTH-1:0] data_q;
    logic             wr;

    assign in_ready = !full_q;
    assign wr       = in_valid && !full_q;
    assign full     = full_q;
    assign out_data = data_q;

    // A write and a pop can never coincide: writes need an empty entry,
    // pops need a full one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
        end else if (clear || pop) begin
            full_q <= 1'b0;
        end else if (wr) begin
            full_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr && !clear) begin
            data_q <= in_data;
        end
    end

endmodule

// File: rtl/serial_bit_feeder.sv
// ---------------------------------------------------------------------------
// serial_bit_feeder
//
// Parallel-to-serial front end for the serial sequence detectors. Accepts
// WIDTH-bit words on a valid/ready handshake and streams them MSB-first, one
// bit per clock. A one-word holding register lets consecutive words follow
// each other with no idle cycle. With no word in flight bit_out = IDLE_BIT.
//
// Parameters
//   WIDTH       data bits per word (2..32)
//   IDLE_BIT    level driven on bit_out while idle
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   flush       in   synchronous abort of held and in-flight words
//   word_in     in   parallel word, bit WIDTH-1 sent first
//   word_valid  in   word_in valid
//   word_ready  out  word can be accepted this cycle
//   bit_out     out  serial bit (registered)
//   bit_valid   out  bit_out carries word data or parity (registered)
//   word_done   out  final bit of a word is on bit_out (registered)
//   busy        out  shifter active or holding register full
//
// Build option
//   SER_PARITY_EN  when defined, each word is followed by one even-parity
//                  bit and word_done marks that parity bit instead of the
//                  last data bit.
// ---------------------------------------------------------------------------
module serial_bit_feeder
    import serial_pkg::*;
#(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CNT_W_RAW = clog2(WIDTH);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < 2 || WIDTH > SER_MAX_WIDTH) begin : g_width_check
            $error("serial_bit_feeder: WIDTH out of range");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] load_word;
    logic             load;

    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             word_done_q, word_done_d;

    logic             hold_full;
    logic             hold_ready;
    logic [WIDTH-1:0] hold_data;
    logic             hold_wr;
    logic             hold_pop;

    logic             last_data;
    logic             last_bit;
    logic             free;
    logic             accept;

`ifdef SER_PARITY_EN
    logic             par_q, par_d;
`endif

    // Engine timing: "free" means the next edge may start a new word.
    assign last_data = (state_q == SHIFT) && (cnt_q == CNT_LAST);
`ifdef SER_PARITY_EN
    assign last_bit  = (state_q == PARITY);
`else
    assign last_bit  = last_data;
`endif
    assign free       = (state_q == IDLE) || last_bit;

    assign word_ready = hold_ready && !flush;
    assign accept     = word_valid && word_ready;

    // Words arriving while the engine is free bypass the holding register.
    assign hold_wr  = word_valid && !flush && !free;
    assign hold_pop = !flush && free && hold_full;

    assign busy = (state_q != IDLE) || hold_full;

    ser_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush),
        .in_valid (hold_wr),
        .in_data  (word_in),
        .in_ready (hold_ready),
        .pop      (hold_pop),
        .out_data (hold_data),
        .full     (hold_full)
    );

    // Next-state: flush beats everything, then load on a free engine,
    // otherwise keep shifting.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        load      = 1'b0;
        load_word = word_in;
`ifdef SER_PARITY_EN
        par_d     = par_q;
`endif

        if (flush) begin
            state_d = IDLE;
        end else if (free) begin
            if (hold_full) begin
                load      = 1'b1;
                load_word = hold_data;
            end else if (accept) begin
                load      = 1'b1;
            end else begin
                state_d   = IDLE;
            end
        end else if (state_q == SHIFT) begin
`ifdef SER_PARITY_EN
            if (last_data) begin
                state_d = PARITY;
            end else begin
                sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
            end
`else
            sh_d  = {sh_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
`endif
        end

        if (load) begin
            state_d = SHIFT;
            cnt_d   = '0;
            sh_d    = load_word;
`ifdef SER_PARITY_EN
            par_d   = ^load_word;
`endif
        end
    end

    // Output registers are computed from the next state so that the stream
    // is glitch-free and lines up with the shifter one edge after a load.
    always_comb begin
        bit_out_d   = IDLE_BIT;
        bit_valid_d = 1'b0;
        word_done_d = 1'b0;
        case (state_d)
            SHIFT: begin
                bit_out_d   = sh_d[WIDTH-1];
                bit_valid_d = 1'b1;
`ifdef SER_PARITY_EN
                word_done_d = 1'b0;
`else
                word_done_d = (cnt_d == CNT_LAST);
`endif
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                bit_out_d   = par_d;
                bit_valid_d = 1'b1;
                word_done_d = 1'b1;
            end
`endif
            default: begin
                bit_out_d   = IDLE_BIT;
                bit_valid_d = 1'b0;
                word_done_d = 1'b0;
            end
        endcase
    end

    // ---- control registers (reset) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_out_q   <= IDLE_BIT;
            bit_valid_q <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            word_done_q <= word_done_d;
        end
    end

    // ---- datapath registers (no reset) ----
    always_ff @(posedge clk) begin
        sh_q  <= sh_d;
`ifdef SER_PARITY_EN
        par_q <= par_d;
`endif
    end

    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign word_done = word_done_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// ---------------------------------------------------------------------------
// tb_serial_bit_feeder
//
// Scoreboard bench for serial_bit_feeder (WIDTH=8, IDLE_BIT=1). The stimulus
// process pushes the expected serial bits of each word as it is accepted; a
// monitor pops and compares on every cycle where bit_valid is high and
// checks the idle level otherwise. Honors SER_PARITY_EN like the design.
// ---------------------------------------------------------------------------
module tb_serial_bit_feeder;

    localparam int W = 8;
`ifdef SER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         flush;
    logic [W-1:0] word_in;
    logic         word_valid;
    logic         word_ready;
    logic         bit_out;
    logic         bit_valid;
    logic         word_done;
    logic         busy;

    serial_bit_feeder #(
        .WIDTH    (W),
        .IDLE_BIT (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .word_done  (word_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic done;
        logic contig;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic prev_valid = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Expected wire image of one word: data MSB first, optional parity bit.
    task automatic push_word(input logic [W-1:0] w, input logic p, input logic contig);
        exp_t e;
        for (int i = W - 1; i >= 0; i--) begin
            e.b      = w[i];
            e.done   = (i == 0) && !PAR;
            e.contig = (i == W - 1) ? contig : 1'b1;
            exp_q.push_back(e);
        end
        if (PAR) begin
            e.b      = p;
            e.done   = 1'b1;
            e.contig = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    // Present a word and wait (bounded) for the accepting edge. Leaves
    // word_valid high; returns 1 ns after the accepting edge.
    task automatic send(input logic [W-1:0] w, input logic p, input logic contig);
        int waited;
        bit ok;
        waited = 0;
        ok     = 1'b0;
        word_in    = w;
        word_valid = 1'b1;
        while (!ok && waited < 40) begin
            @(negedge clk);
            if (word_ready) begin
                push_word(w, p, contig);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
            waited++;
        end
        chk("accept_timeout", {31'd0, ok}, 32'd1);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst) begin
            if (bit_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_bit", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("bit_out", {31'd0, bit_out}, {31'd0, e.b});
                    chk("word_done", {31'd0, word_done}, {31'd0, e.done});
                    if (e.contig) begin
                        chk("gap_before_bit", {31'd0, prev_valid}, 32'd1);
                    end
                end
                if (word_done) done_q.push_back(cyc);
            end else begin
                chk("idle_bit_out", {31'd0, bit_out}, 32'd1);
                chk("idle_word_done", {31'd0, word_done}, 32'd0);
            end
            prev_valid = bit_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        word_valid = 1'b0;
        word_in    = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Reset / idle for 10 cycles
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_word_done", {31'd0, word_done}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_bit", {31'd0, bit_out}, 32'd1);
            chk("idle_valid", {31'd0, bit_valid}, 32'd0);
            chk("idle_ready", {31'd0, word_ready}, 32'd1);
        end
        @(posedge clk); #1;

        // Single word 8'h24
        done_q.delete();
        send(8'h24, 1'b0, 1'b0);
        word_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        chk("single_done_pulses", done_q.size(), 32'd1);
        chk("single_busy_after", {31'd0, busy}, 32'd0);

        // Back-to-back 8'hA5 then 8'h3C
        send(8'hA5, 1'b0, 1'b0);
        send(8'h3C, 1'b0, 1'b1);
        word_valid = 1'b0;
        @(negedge clk);
        chk("ready_low_hold_full", {31'd0, word_ready}, 32'd0);
        chk("busy_hold_full", {31'd0, busy}, 32'd1);
        repeat (22) @(posedge clk);
        #1;

        // Three words with word_valid held high
        done_q.delete();
        send(8'h07, 1'b1, 1'b0);
        send(8'h81, 1'b0, 1'b1);
        send(8'h7F, 1'b1, 1'b1);
        word_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("three_done_pulses", done_q.size(), 32'd3);
        if (done_q.size() == 3) begin
            chk("done_spacing_1", done_q[1] - done_q[0], W + PAR);
            chk("done_spacing_2", done_q[2] - done_q[1], W + PAR);
        end

        // Flush at bit 3 of 8'hFF with 8'h00 held
        send(8'hFF, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b1);
        word_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("ready_low_in_flush", {31'd0, word_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_idle_valid", {31'd0, bit_valid}, 32'd0);
        chk("flush_idle_bit", {31'd0, bit_out}, 32'd1);
        chk("flush_ready", {31'd0, word_ready}, 32'd1);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        repeat (14) @(posedge clk);
        #1;

        // Single word 8'h07 (parity 1 when enabled)
        done_q.delete();
        send(8'h07, 1'b1, 1'b0);
        word_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        chk("w07_done_pulses", done_q.size(), 32'd1);

        // Asynchronous reset in the middle of a word
        send(8'h5A, 1'b0, 1'b0);
        word_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, bit_valid}, 32'd0);
        chk("arst_bit", {31'd0, bit_out}, 32'd1);
        chk("arst_done", {31'd0, word_done}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_ready", {31'd0, word_ready}, 32'd1);
        exp_q.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
